gpio_ctrl: RTL and testbench
============================

# gpio_ctrl

Core-side controller for a bank of W bidirectional pad cells. It drives each pad cell's di/oe/ie/pu/pd controls from software-visible registers. It samples each pad cell's dc return through a two-flop synchronizer, an optional debounce filter and rise/fall edge detection. It raises a level interrupt on enabled edges and sits between the register bus and the pad ring.

## Interface
Parameters:
- W, 8, number of pins in the bank
- DB_W, 4, debounce counter width; DB_MAX = 2^DB_W-1

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- we  in  1  register write strobe
- re  in  1  register read strobe
- addr  in  4  register index
- wdata  in  W  write data
- rdata  out  W  read data
- di  out  W  per-pin output data to pad cell
- oe  out  W  per-pin output enable
- ie  out  W  per-pin input enable
- pu  out  W  per-pin pull-up
- pd  out  W  per-pin pull-down
- dc  in  W  per-pin data from pad cell, asynchronous
- irq  out  1  level interrupt

## Operation
- Register map, one bit per pin:
  - 0 OUT
  - 1 OE
  - 2 IE
  - 3 PU
  - 4 PD
  - 5 IN (read-only)
  - 6 RISE_EN
  - 7 FALL_EN
  - 8 STAT (write-1-to-clear)
- Writes to IN, and reads or writes of addresses 9-15, are ignored. Reads of those addresses return 0.
- Pad controls:
  - di=OUT, oe=OE, ie=IE, pu=PU.
  - pd=PD & ~PU; pull-up wins when both bits are set.
- Input path, per pin:
  - The synchronizer input is dc & IE, so a disabled pin samples 0 and a floating pad never propagates X.
  - Two flops, s1 then s2.
- Debounce (macro-dependent, see Configuration):
  - A per-pin counter increments each cycle while s2 != IN, and clears when s2 == IN.
  - When s2 != IN and the counter == DB_MAX, IN takes s2 and the counter clears.
  - A mismatch must therefore persist DB_MAX+1 consecutive cycles.
- Edge detection:
  - in_q is IN delayed one cycle.
  - rise = IN & ~in_q & RISE_EN; fall = ~IN & in_q & FALL_EN.
  - A detected edge sets its STAT bit.
- STAT clear: a write to STAT clears the bits written as 1. If a set and a clear hit the same bit in the same cycle, the set wins.
- irq = |STAT (OR of flops, no extra stage).

## Timing
- Reset: all registers, synchronizer flops, counters, in_q, rdata and irq are 0. Therefore di=oe=ie=pu=pd=0 and all pads are released.
- Writes take effect at the clock edge where we=1; the pad control outputs change on that edge.
- rdata is registered and valid the cycle after re=1; otherwise it holds its value.
- Read and write to the same address in the same cycle: rdata returns the pre-write value.
- dc to IN, without debounce: IN=s2, so the change is visible after 2 edges.
- dc to IN, with debounce: 2+DB_MAX+1 edges.
- STAT bit is set 1 edge after IN changes; irq is high in the same cycle as STAT.
- Clearing IE forces the synchronizer input to 0. A resulting fall is detected normally if FALL_EN is set.
- Asserting rst mid-operation clears everything immediately (asynchronous). Debounce progress is lost.

## Configuration
- GPIO_DEBOUNCE_EN defined: per-pin DB_W-bit debounce counters are instantiated as described.
- GPIO_DEBOUNCE_EN undefined:
  - IN is s2 directly.
  - No counters are built and DB_W is unused.
  - Register map and all other behaviour are unchanged.

## Structure
- Shared package gpio_pkg holds:
  - register index constants (GPIO_OUT … GPIO_STAT)
  - the address width constant (4)
- One sub-module, gpio_sync_db, instantiated W times. It contains the per-pin two-flop synchronizer, the debounce counter under GPIO_DEBOUNCE_EN, and the IN output.
- Registers, edge detection, STAT and the read mux stay in gpio_ctrl.

## Test plan
- Reset: assert rst mid-run with registers loaded → all outputs 0 asynchronously; a read of OE after release returns 0.
- Write OUT=0xA5, OE=0x0F, PU=0x03, PD=0x06 → di=0xA5, oe=0x0F, pu=0x03, pd=0x04 on the next edge. Each readback appears 1 cycle after re.
- IE=0xFF, DB_W=4, debounce compiled in:
  - dc bit0 0→1 held 20 cycles → IN bit0=1 exactly 18 edges after the change.
  - A 10-cycle pulse on bit1 → IN unchanged.
- RISE_EN=0x01: bit0 rises → STAT=0x01 and irq=1 one edge after IN changes. Write STAT=0x01 → irq=0.
- Same-cycle STAT W1C and new edge on bit0 → STAT bit0 stays 1.
- IE=0x00 with dc=0xFF → IN reads 0. Set IE=0x01 with RISE_EN=0x01 → rise detected and STAT=0x01.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: register indices and bus address width shared by the GPIO
// controller, its bus interface and the testbench.
package gpio_pkg;

    localparam int GPIO_AW = 4;

    localparam logic [GPIO_AW-1:0] GPIO_OUT     = 4'd0;
    localparam logic [GPIO_AW-1:0] GPIO_OE      = 4'd1;
    localparam logic [GPIO_AW-1:0] GPIO_IE      = 4'd2;
    localparam logic [GPIO_AW-1:0] GPIO_PU      = 4'd3;
    localparam logic [GPIO_AW-1:0] GPIO_PD      = 4'd4;
    localparam logic [GPIO_AW-1:0] GPIO_IN      = 4'd5;
    localparam logic [GPIO_AW-1:0] GPIO_RISE_EN = 4'd6;
    localparam logic [GPIO_AW-1:0] GPIO_FALL_EN = 4'd7;
    localparam logic [GPIO_AW-1:0] GPIO_STAT    = 4'd8;

endpackage

// File: rtl/gpio_if.sv
// gpio_if: simple register bus (write/read strobes, index, data) between a
// bus master and the GPIO controller. rdata is returned one cycle after re.
interface gpio_if #(
    parameter int W = 8
) ();
    import gpio_pkg::*;

    logic               we;
    logic               re;
    logic [GPIO_AW-1:0] addr;
    logic [W-1:0]       wdata;
    logic [W-1:0]       rdata;

    modport master (
        output we, re, addr, wdata,
        input  rdata
    );

    modport slave (
        input  we, re, addr, wdata,
        output rdata
    );

endinterface

// File: rtl/gpio_sync_db.sv
// gpio_sync_db: per-pin input path. Two-flop synchronizer followed, when
// GPIO_DEBOUNCE_EN is defined, by a DB_W-bit debounce counter; in_o is the
// pin's IN value. Without GPIO_DEBOUNCE_EN, in_o is the second sync flop.
module gpio_sync_db #(
    parameter int DB_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic in_o
);

    logic s1_q;
    logic s2_q;

    // Two-flop synchronizer for the asynchronous pad return.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s2_next(s1_q);
        end
    end

    function automatic logic s2_next(input logic v);
        return v;
    endfunction

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [DB_W-1:0] DB_MAX = '1;

    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;
    logic            in_q;
    logic            in_d;

    // A mismatch must persist DB_MAX+1 cycles before IN follows s2.
    always_comb begin
        cnt_d = '0;
        in_d  = in_q;
        if (s2_q != in_q) begin
            if (cnt_q == DB_MAX) begin
                in_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce counter and filtered IN state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            in_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            in_q  <= in_d;
        end
    end

    assign in_o = in_q;
`else
    // DB_W has no effect in this build; the empty guard keeps it referenced.
    if (DB_W < 1) begin : g_db_w_unused
    end

    assign in_o = s2_q;
`endif

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: core-side controller for a bank of W pad cells. Holds the
// software registers, drives pad controls, detects rise/fall on the
// synchronized inputs, and raises irq while any STAT bit is set.
// Optional debounce is built when GPIO_DEBOUNCE_EN is defined.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int W    = 8,
    parameter int DB_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    gpio_if.slave        bus,
    output logic [W-1:0] di,
    output logic [W-1:0] oe,
    output logic [W-1:0] ie,
    output logic [W-1:0] pu,
    output logic [W-1:0] pd,
    input  logic [W-1:0] dc,
    output logic         irq
);

    logic [W-1:0] out_q;
    logic [W-1:0] oe_q;
    logic [W-1:0] ie_q;
    logic [W-1:0] pu_q;
    logic [W-1:0] pd_q;
    logic [W-1:0] rise_en_q;
    logic [W-1:0] fall_en_q;
    logic [W-1:0] stat_q;
    logic [W-1:0] stat_d;
    logic [W-1:0] in_dly_q;
    logic [W-1:0] rdata_q;
    logic [W-1:0] rdata_d;
    logic [W-1:0] pin_in;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] stat_clr;

    // Per-pin input path; a disabled pin samples 0 so a floating pad never
    // reaches the synchronizer.
    for (genvar i = 0; i < W; i++) begin : g_pin
        gpio_sync_db #(
            .DB_W (DB_W)
        ) u_sync_db (
            .clk  (clk),
            .rst  (rst),
            .d_i  (dc[i] & ie_q[i]),
            .in_o (pin_in[i])
        );
    end

    // Software-writable control registers; IN and unmapped indices ignore writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            oe_q      <= '0;
            ie_q      <= '0;
            pu_q      <= '0;
            pd_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (bus.we) begin
            case (bus.addr)
                GPIO_OUT:     out_q     <= bus.wdata;
                GPIO_OE:      oe_q      <= bus.wdata;
                GPIO_IE:      ie_q      <= bus.wdata;
                GPIO_PU:      pu_q      <= bus.wdata;
                GPIO_PD:      pd_q      <= bus.wdata;
                GPIO_RISE_EN: rise_en_q <= bus.wdata;
                GPIO_FALL_EN: fall_en_q <= bus.wdata;
                default:      ;
            endcase
        end
    end

    // Edge detection against IN delayed by one cycle.
    assign rise = pin_in & ~in_dly_q & rise_en_q;
    assign fall = ~pin_in & in_dly_q & fall_en_q;

    // W1C on STAT; a new edge in the same cycle wins over the clear.
    assign stat_clr = (bus.we && bus.addr == GPIO_STAT) ? bus.wdata : '0;
    assign stat_d   = (stat_q & ~stat_clr) | rise | fall;

    // Read mux; captured only on re, so rdata holds otherwise.
    always_comb begin
        // NOTE: default first so every path assigns rdata_d and no latch forms.
        rdata_d = rdata_q;
        if (bus.re) begin
            case (bus.addr)
                GPIO_OUT:     rdata_d = out_q;
                GPIO_OE:      rdata_d = oe_q;
                GPIO_IE:      rdata_d = ie_q;
                GPIO_PU:      rdata_d = pu_q;
                GPIO_PD:      rdata_d = pd_q;
                GPIO_IN:      rdata_d = pin_in;
                GPIO_RISE_EN: rdata_d = rise_en_q;
                GPIO_FALL_EN: rdata_d = fall_en_q;
                GPIO_STAT:    rdata_d = stat_q;
                default:      rdata_d = '0;
            endcase
        end
    end

    // Status, IN history and read data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q   <= '0;
            in_dly_q <= '0;
            rdata_q  <= '0;
        end else begin
            stat_q   <= stat_d;
            in_dly_q <= pin_in;
            rdata_q  <= rdata_d;
        end
    end

    assign di        = out_q;
    assign oe        = oe_q;
    assign ie        = ie_q;
    assign pu        = pu_q;
    assign pd        = pd_q & ~pu_q;
    assign irq       = |stat_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed bench for gpio_ctrl. Register reads push their
// expected value into a queue; a monitor pops and compares when the read
// response is presented. Pad and irq levels are checked directly.
// Expected input latency follows GPIO_DEBOUNCE_EN (DB_W = 4).
`timescale 1ns/1ps
module tb_gpio_ctrl;
    import gpio_pkg::*;

    localparam int W = 8;
`ifdef GPIO_DEBOUNCE_EN
    localparam bit DEBOUNCE = 1'b1;
    localparam int LAT      = 2 + 15 + 1;
`else
    localparam bit DEBOUNCE = 1'b0;
    localparam int LAT      = 2;
`endif

    typedef struct {
        string        name;
        logic [W-1:0] data;
    } rd_exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] di, oe, ie, pu, pd, dc;
    logic         irq;

    gpio_if #(.W(W)) bus ();

    gpio_ctrl #(
        .W    (W),
        .DB_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .di  (di),
        .oe  (oe),
        .ie  (ie),
        .pu  (pu),
        .pd  (pd),
        .dc  (dc),
        .irq (irq)
    );

    rd_exp_t exp_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input logic [W-1:0] data);
        rd_exp_t e;
        e.name = name;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: a read sampled at a posedge has its data on the next negedge.
    initial begin : monitor
        logic    pend;
        rd_exp_t e;
        forever begin
            @(posedge clk);
            pend = bus.re;
            @(negedge clk);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected read: got 0x%0h, expected no response", bus.rdata);
                end else begin
                    e = exp_q.pop_front();
                    check(e.name, bus.rdata, e.data);
                end
            end
        end
    end

    task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.we    = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [W-1:0] e, input string name);
        push_exp(name, e);
        bus.re   = 1'b1;
        bus.addr = a;
        @(negedge clk);
        bus.re   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        logic [W-1:0] e;
        rst       = 1'b1;
        bus.we    = 1'b0;
        bus.re    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        dc        = '0;

        // Reset state
        @(negedge clk);
        check("reset di", di, 0);
        check("reset oe", oe, 0);
        check("reset ie", ie, 0);
        check("reset pu", pu, 0);
        check("reset pd", pd, 0);
        check("reset irq", irq, 0);
        check("reset rdata", bus.rdata, 0);
        rst = 1'b0;
        idle(1);

        // Pad control writes and readback
        wr(GPIO_OUT, 8'hA5);
        check("di after write", di, 8'hA5);
        wr(GPIO_OE, 8'h0F);
        check("oe after write", oe, 8'h0F);
        wr(GPIO_PU, 8'h03);
        wr(GPIO_PD, 8'h06);
        check("pu after write", pu, 8'h03);
        check("pd pull-up wins", pd, 8'h04);
        rd(GPIO_OUT, 8'hA5, "rd OUT");
        rd(GPIO_OE, 8'h0F, "rd OE");
        rd(GPIO_PU, 8'h03, "rd PU");
        rd(GPIO_PD, 8'h06, "rd PD raw");
        idle(1);
        check("rdata hold", bus.rdata, 8'h06);
        wr(GPIO_IN, 8'hFF);
        rd(GPIO_IN, 8'h00, "IN write ignored");
        wr(4'd9, 8'hFF);
        rd(4'd9, 8'h00, "rd addr 9");
        rd(4'd15, 8'h00, "rd addr 15");
        rd(GPIO_OUT, 8'hA5, "OUT after addr9 write");

        // Read and write of the same address in one cycle
        push_exp("rd/wr same cycle", 8'hA5);
        bus.we    = 1'b1;
        bus.re    = 1'b1;
        bus.addr  = GPIO_OUT;
        bus.wdata = 8'h3C;
        @(negedge clk);
        bus.we    = 1'b0;
        bus.re    = 1'b0;
        check("di after rd/wr", di, 8'h3C);
        rd(GPIO_OUT, 8'h3C, "rd OUT new");

        // Input latency and rise interrupt on bit0
        wr(GPIO_IE, 8'hFF);
        wr(GPIO_RISE_EN, 8'h01);
        check("ie after write", ie, 8'hFF);
        dc = 8'h01;
        for (int k = 1; k <= LAT + 3; k++) begin
            push_exp($sformatf("IN latency k=%0d", k), (k - 1 >= LAT) ? 8'h01 : 8'h00);
            bus.re   = 1'b1;
            bus.addr = GPIO_IN;
            @(negedge clk);
            check($sformatf("irq timing k=%0d", k), irq, (k >= LAT + 1) ? 1 : 0);
        end
        bus.re = 1'b0;
        rd(GPIO_STAT, 8'h01, "STAT after rise");

        // W1C clears irq
        wr(GPIO_STAT, 8'h01);
        check("irq after W1C", irq, 0);
        rd(GPIO_STAT, 8'h00, "STAT after W1C");

        // 10-cycle pulse on bit1
        for (int k = 1; k <= 20; k++) begin
            dc = (k <= 10) ? 8'h03 : 8'h01;
            e  = 8'h01;
            if (!DEBOUNCE && (k - 1) >= 2 && (k - 1) <= 11) e = 8'h03;
            push_exp($sformatf("pulse IN k=%0d", k), e);
            bus.re   = 1'b1;
            bus.addr = GPIO_IN;
            @(negedge clk);
        end
        bus.re = 1'b0;
        dc     = 8'h01;
        check("irq after pulse", irq, 0);

        // Same-cycle W1C and new rise on bit0: set wins
        dc = 8'h00;
        idle(LAT + 3);
        check("irq after fall, FALL_EN=0", irq, 0);
        dc = 8'h01;
        for (int k = 1; k <= LAT + 1; k++) begin
            if (k == LAT + 1) begin
                bus.we    = 1'b1;
                bus.addr  = GPIO_STAT;
                bus.wdata = 8'h01;
            end
            @(negedge clk);
        end
        bus.we = 1'b0;
        check("irq set wins", irq, 1);
        rd(GPIO_STAT, 8'h01, "STAT set wins");
        wr(GPIO_STAT, 8'h01);
        check("irq cleared", irq, 0);

        // IE gating and rise on enable
        wr(GPIO_IE, 8'h00);
        dc = 8'hFF;
        idle(LAT + 3);
        rd(GPIO_IN, 8'h00, "IN with IE=0");
        check("irq with IE=0", irq, 0);
        wr(GPIO_IE, 8'h01);
        idle(LAT + 3);
        check("irq rise on IE", irq, 1);
        rd(GPIO_STAT, 8'h01, "STAT rise on IE");
        rd(GPIO_IN, 8'h01, "IN with IE=1");

        // Clearing IE produces a fall
        wr(GPIO_STAT, 8'hFF);
        wr(GPIO_FALL_EN, 8'h01);
        check("irq before IE clear", irq, 0);
        wr(GPIO_IE, 8'h00);
        idle(LAT + 3);
        rd(GPIO_STAT, 8'h01, "STAT fall on IE clear");
        check("irq fall on IE clear", irq, 1);

        // Asynchronous reset mid-run
        check("oe loaded before reset", oe, 8'h0F);
        #2;
        rst = 1'b1;
        #1;
        check("async reset di", di, 0);
        check("async reset oe", oe, 0);
        check("async reset pu", pu, 0);
        check("async reset pd", pd, 0);
        check("async reset irq", irq, 0);
        check("async reset rdata", bus.rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        rd(GPIO_OE, 8'h00, "OE after reset");
        rd(GPIO_STAT, 8'h00, "STAT after reset");
        idle(2);

        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
